tpmem_pingpong: RTL and testbench

Parametrised, double-buffered transpose memory for the 2-D transform datapath. It accepts an N×N block of BW-bit samples one row per cycle and emits the block either transposed (column per cycle) or in row order, selected per frame. The output is zero-padded to OUT_LANES lanes. Two banks let one frame be written while the previous one is read, so streaming runs at full throughput. A ready/valid handshake on both sides absorbs downstream stalls.

---
 rtl/tpmem_pingpong.sv | 131 +++++++++++++
 tb/tb_tpmem_pingpong.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tpmem_pingpong.sv
// Double-buffered N x N transpose memory.
// Rows are written into one bank while the other bank is read out, either
// column by column (transpose mode) or row by row. The mode is captured with
// row 0 of each frame. Output lanes N..OUT_LANES-1 are always zero.
module tpmem_pingpong #(
  parameter int BW        = 12,
  parameter int N         = 6,
  parameter int OUT_LANES = 8
) (
  input  logic                    i_clk,
  input  logic                    i_Reset,
  input  logic [N*BW-1:0]         i_data,
  input  logic                    i_valid,
  input  logic                    i_transpose,
  output logic                    o_ready,
  output logic [OUT_LANES*BW-1:0] o_data,
  output logic                    o_en,
  output logic                    o_sof,
  input  logic                    i_ready
);

  localparam int IW = $clog2(N);

  logic [BW-1:0]           r_mem [2][N][N];
  logic [1:0]              r_full;
  logic [1:0]              r_mode;
  logic                    r_wr_sel;
  logic                    r_rd_sel;
  logic [IW-1:0]           r_wr_row;
  logic [IW-1:0]           r_rd_idx;
  logic [OUT_LANES*BW-1:0] r_data;
  logic                    r_en;
  logic                    r_sof;

  logic                    w_wr;
  logic                    w_rd;
  logic                    w_wr_last;
  logic                    w_rd_last;
  logic [1:0]              w_set;
  logic [1:0]              w_clr;
  logic [OUT_LANES*BW-1:0] w_vec;

  // A bank is writable only while its full flag is clear; a vector loads
  // whenever the output register is empty or being consumed.
  assign o_ready   = !r_full[r_wr_sel];
  assign w_wr      = i_valid && !r_full[r_wr_sel];
  assign w_rd      = r_full[r_rd_sel] && (!r_en || i_ready);
  assign w_wr_last = w_wr && (r_wr_row == IW'(N-1));
  assign w_rd_last = w_rd && (r_rd_idx == IW'(N-1));
  assign w_set     = w_wr_last ? (2'b01 << r_wr_sel) : 2'b00;
  assign w_clr     = w_rd_last ? (2'b01 << r_rd_sel) : 2'b00;

  assign o_data = r_data;
  assign o_en   = r_en;
  assign o_sof  = r_sof;

  // Store an accepted row; storage needs no reset because full flags gate reads.
  always_ff @(posedge i_clk) begin
    if (w_wr) begin
      for (int c = 0; c < N; c++) begin
        r_mem[r_wr_sel][r_wr_row][c] <= i_data[(N-c)*BW-1 -: BW];
      end
    end
  end

  // Write pointer, row counter and per-bank mode capture on row 0.
  always_ff @(posedge i_clk) begin
    if (!i_Reset) begin
      r_wr_sel <= 1'b0;
      r_wr_row <= '0;
      r_mode   <= 2'b00;
    end else if (w_wr) begin
      if (r_wr_row == '0) begin
        r_mode[r_wr_sel] <= i_transpose;
      end
      if (r_wr_row == IW'(N-1)) begin
        r_wr_row <= '0;
        r_wr_sel <= ~r_wr_sel;
      end else begin
        r_wr_row <= r_wr_row + IW'(1);
      end
    end
  end

  // Full flags: set by the last written row, cleared by the last read vector.
  // Set and clear never target the same bank on the same edge.
  always_ff @(posedge i_clk) begin
    if (!i_Reset) begin
      r_full <= 2'b00;
    end else begin
      r_full <= (r_full | w_set) & ~w_clr;
    end
  end

  // Select column or row rstate of the read bank; unused lanes stay zero.
  always_comb begin
    w_vec = '0;
    for (int r = 0; r < N; r++) begin
      if (r_mode[r_rd_sel]) begin
        w_vec[(OUT_LANES-r)*BW-1 -: BW] = r_mem[r_rd_sel][r][r_rd_idx];
      end else begin
        w_vec[(OUT_LANES-r)*BW-1 -: BW] = r_mem[r_rd_sel][r_rd_idx][r];
      end
    end
  end

  // Output register with hold-on-stall and read pointer advance.
  always_ff @(posedge i_clk) begin
    if (!i_Reset) begin
      r_data   <= '0;
      r_en     <= 1'b0;
      r_sof    <= 1'b0;
      r_rd_sel <= 1'b0;
      r_rd_idx <= '0;
    end else if (w_rd) begin
      r_data <= w_vec;
      r_en   <= 1'b1;
      r_sof  <= (r_rd_idx == '0);
      if (r_rd_idx == IW'(N-1)) begin
        r_rd_idx <= '0;
        r_rd_sel <= ~r_rd_sel;
      end else begin
        r_rd_idx <= r_rd_idx + IW'(1);
      end
    end else if (i_ready) begin
      r_en  <= 1'b0;
      r_sof <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tpmem_pingpong.sv
// Directed bench for tpmem_pingpong: reset, both modes, streaming,
// backpressure and mid-frame reset, with hand-built expected vectors.
module tb_tpmem_pingpong;

  localparam int BW = 12;
  localparam int N  = 6;
  localparam int OL = 8;

  logic              clk;
  logic              i_Reset;
  logic [N*BW-1:0]   i_data;
  logic              i_valid;
  logic              i_transpose;
  logic              o_ready;
  logic [OL*BW-1:0]  o_data;
  logic              o_en;
  logic              o_sof;
  logic              i_ready;

  int total;
  int bad;

  tpmem_pingpong #(.BW(BW), .N(N), .OUT_LANES(OL)) dut (
    .i_clk       (clk),
    .i_Reset     (i_Reset),
    .i_data      (i_data),
    .i_valid     (i_valid),
    .i_transpose (i_transpose),
    .o_ready     (o_ready),
    .o_data      (o_data),
    .o_en        (o_en),
    .o_sof       (o_sof),
    .i_ready     (i_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Row r of a frame with base b: element c = b + 0x10*r + c.
  function automatic logic [N*BW-1:0] mk_row(input int b, input int r);
    logic [N*BW-1:0] v;
    v = '0;
    for (int c = 0; c < N; c++) v[(N-c)*BW-1 -: BW] = BW'(b + 16*r + c);
    return v;
  endfunction

  // Expected output vector k of a frame with base b in mode m.
  function automatic logic [OL*BW-1:0] mk_vec(input int b, input bit m, input int k);
    logic [OL*BW-1:0] v;
    v = '0;
    for (int r = 0; r < N; r++)
      v[(OL-r)*BW-1 -: BW] = m ? BW'(b + 16*r + k) : BW'(b + 16*k + r);
    return v;
  endfunction

  task automatic do_reset();
    i_Reset = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b1;
    i_transpose = 1'b0;
    i_data = '0;
    repeat (2) @(posedge clk);
    #1;
    i_Reset = 1'b1;
  endtask

  // Drive n rows back to back; mode is only meaningful on row 0, so later
  // rows carry the opposite value on purpose.
  task automatic send_rows(input int b, input bit m, input int n);
    for (int r = 0; r < n; r++) begin
      i_valid = 1'b1;
      i_data = mk_row(b, r);
      i_transpose = (r == 0) ? m : !m;
      @(posedge clk);
      #1;
    end
    i_valid = 1'b0;
  endtask

  task automatic test_reset();
    i_Reset = 1'b0;
    i_valid = 1'b1;
    i_ready = 1'b1;
    i_transpose = 1'b1;
    i_data = mk_row(16'h700, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      total++;
      if (o_en !== 1'b0) begin bad++; $display("FAIL reset_en cyc=%0d got=%b want=0", i, o_en); end
      total++;
      if (o_data !== '0) begin bad++; $display("FAIL reset_data cyc=%0d got=%h want=0", i, o_data); end
      total++;
      if (o_ready !== 1'b1) begin bad++; $display("FAIL reset_ready cyc=%0d got=%b want=1", i, o_ready); end
      total++;
      if (o_sof !== 1'b0) begin bad++; $display("FAIL reset_sof cyc=%0d got=%b want=0", i, o_sof); end
    end
    i_valid = 1'b0;
    i_Reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      total++;
      if (o_en !== 1'b0) begin bad++; $display("FAIL reset_nostore cyc=%0d got=%b want=0", i, o_en); end
    end
  endtask

  task automatic test_transpose();
    do_reset();
    send_rows(0, 1'b1, N);
    total++;
    if (o_en !== 1'b0) begin bad++; $display("FAIL xpose_latency got=%b want=0", o_en); end
    for (int k = 0; k < N; k++) begin
      @(posedge clk);
      #1;
      total++;
      if (o_en !== 1'b1) begin bad++; $display("FAIL xpose_en k=%0d got=%b want=1", k, o_en); end
      total++;
      if (o_data !== mk_vec(0, 1'b1, k)) begin
        bad++; $display("FAIL xpose_data k=%0d got=%h want=%h", k, o_data, mk_vec(0, 1'b1, k));
      end
      total++;
      if (o_sof !== (k == 0)) begin bad++; $display("FAIL xpose_sof k=%0d got=%b want=%b", k, o_sof, (k == 0)); end
    end
    @(posedge clk);
    #1;
    total++;
    if (o_en !== 1'b0) begin bad++; $display("FAIL xpose_en_drop got=%b want=0", o_en); end
  endtask

  task automatic test_row_mode();
    do_reset();
    send_rows(0, 1'b0, N);
    for (int k = 0; k < N; k++) begin
      @(posedge clk);
      #1;
      total++;
      if (o_en !== 1'b1) begin bad++; $display("FAIL row_en k=%0d got=%b want=1", k, o_en); end
      total++;
      if (o_data !== mk_vec(0, 1'b0, k)) begin
        bad++; $display("FAIL row_data k=%0d got=%h want=%h", k, o_data, mk_vec(0, 1'b0, k));
      end
      total++;
      if (o_sof !== (k == 0)) begin bad++; $display("FAIL row_sof k=%0d got=%b want=%b", k, o_sof, (k == 0)); end
    end
    @(posedge clk);
    #1;
    total++;
    if (o_en !== 1'b0) begin bad++; $display("FAIL row_en_drop got=%b want=0", o_en); end
  endtask

  task automatic test_streaming();
    int  base [3];
    bit  mode [3];
    int  v, f, k;
    base = '{16'h100, 16'h200, 16'h300};
    mode = '{1'b1, 1'b0, 1'b1};
    do_reset();
    for (int t = 0; t <= 4*N; t++) begin
      if (t < 3*N) begin
        i_valid = 1'b1;
        i_data = mk_row(base[t/N], t%N);
        i_transpose = (t%N == 0) ? mode[t/N] : !mode[t/N];
        total++;
        if (o_ready !== 1'b1) begin bad++; $display("FAIL stream_ready t=%0d got=%b want=1", t, o_ready); end
      end else begin
        i_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      if (t < N || t == 4*N) begin
        total++;
        if (o_en !== 1'b0) begin bad++; $display("FAIL stream_idle t=%0d got=%b want=0", t, o_en); end
      end else begin
        v = t - N;
        f = v / N;
        k = v % N;
        total++;
        if (o_en !== 1'b1) begin bad++; $display("FAIL stream_en t=%0d got=%b want=1", t, o_en); end
        total++;
        if (o_data !== mk_vec(base[f], mode[f], k)) begin
          bad++; $display("FAIL stream_data f=%0d k=%0d got=%h want=%h", f, k, o_data, mk_vec(base[f], mode[f], k));
        end
        total++;
        if (o_sof !== (k == 0)) begin bad++; $display("FAIL stream_sof f=%0d k=%0d got=%b", f, k, o_sof); end
      end
    end
  endtask

  task automatic test_backpressure();
    int  f, k, b;
    bit  m;
    do_reset();
    i_ready = 1'b0;
    send_rows(16'h400, 1'b1, N);
    total++;
    if (o_en !== 1'b0) begin bad++; $display("FAIL bp_pre_en got=%b want=0", o_en); end
    send_rows(16'h500, 1'b0, N);
    total++;
    if (o_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_low got=%b want=0", o_ready); end
    // Offer a row that must be dropped.
    i_valid = 1'b1;
    i_data = mk_row(16'hF00, 0);
    i_transpose = 1'b0;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (o_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_hold i=%0d got=%b want=0", i, o_ready); end
      total++;
      if (o_en !== 1'b1 || o_sof !== 1'b1) begin
        bad++; $display("FAIL bp_ctl_hold i=%0d got en=%b sof=%b want 1 1", i, o_en, o_sof);
      end
      total++;
      if (o_data !== mk_vec(16'h400, 1'b1, 0)) begin
        bad++; $display("FAIL bp_data_hold i=%0d got=%h want=%h", i, o_data, mk_vec(16'h400, 1'b1, 0));
      end
      @(posedge clk);
      #1;
    end
    i_ready = 1'b1;
    for (int v = 1; v < 2*N; v++) begin
      @(posedge clk);
      #1;
      f = v / N;
      k = v % N;
      b = f ? 16'h500 : 16'h400;
      m = f ? 1'b0 : 1'b1;
      total++;
      if (o_en !== 1'b1) begin bad++; $display("FAIL bp_en v=%0d got=%b want=1", v, o_en); end
      total++;
      if (o_data !== mk_vec(b, m, k)) begin
        bad++; $display("FAIL bp_data v=%0d got=%h want=%h", v, o_data, mk_vec(b, m, k));
      end
      total++;
      if (o_sof !== (k == 0)) begin bad++; $display("FAIL bp_sof v=%0d got=%b", v, o_sof); end
      if (v == N-1) begin
        total++;
        if (o_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_rise got=%b want=1", o_ready); end
      end
    end
    @(posedge clk);
    #1;
    total++;
    if (o_en !== 1'b0) begin bad++; $display("FAIL bp_en_drop got=%b want=0", o_en); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    send_rows(16'h600, 1'b0, 3);
    i_Reset = 1'b0;
    @(posedge clk);
    #1;
    i_Reset = 1'b1;
    total++;
    if (o_ready !== 1'b1 || o_en !== 1'b0) begin
      bad++; $display("FAIL midrst_state got ready=%b en=%b want 1 0", o_ready, o_en);
    end
    send_rows(16'h200, 1'b1, N);
    total++;
    if (o_en !== 1'b0) begin bad++; $display("FAIL midrst_early got=%b want=0", o_en); end
    for (int k = 0; k < N; k++) begin
      @(posedge clk);
      #1;
      total++;
      if (o_en !== 1'b1) begin bad++; $display("FAIL midrst_en k=%0d got=%b want=1", k, o_en); end
      total++;
      if (o_data !== mk_vec(16'h200, 1'b1, k)) begin
        bad++; $display("FAIL midrst_data k=%0d got=%h want=%h", k, o_data, mk_vec(16'h200, 1'b1, k));
      end
      total++;
      if (o_sof !== (k == 0)) begin bad++; $display("FAIL midrst_sof k=%0d got=%b", k, o_sof); end
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      total++;
      if (o_en !== 1'b0) begin bad++; $display("FAIL midrst_tail i=%0d got=%b want=0", i, o_en); end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    i_Reset = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b1;
    i_transpose = 1'b0;
    i_data = '0;
    test_reset();
    test_transpose();
    test_row_mode();
    test_streaming();
    test_backpressure();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
